triangle_sweep_ctrl: RTL and testbench
======================================

TRIANGLE_SWEEP_CTRL -- requirements
Module: triangle_sweep_ctrl

Interface
REQ-001 SHALL have parameter TOTAL_PREC, default 27, fixed-point word width.
REQ-002 SHALL have parameter TRI_AW, default 10, triangle-memory address width.
REQ-003 SHALL have parameter PIPE_LAT, default 8, cycles from intersect-datapath input to hit/t/oa output.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports ray_valid input 1, ray_ready output 1  ray request handshake.
REQ-007 SHALL have port ray_dir  input  3x TOTAL_PREC signed  ray direction, captured on ray handshake.
REQ-008 SHALL have port tri_count  input  TRI_AW+1  number of triangles to sweep, sampled on ray handshake.
REQ-009 SHALL have ports tri_rd_en output 1, tri_addr output TRI_AW  triangle-memory read; data reaches the datapath 1 cycle later.
REQ-010 SHALL have port isect_dir  output  3x TOTAL_PREC signed  captured direction driven to the datapath.
REQ-011 SHALL have ports isect_hit input 1, isect_t input TOTAL_PREC signed, isect_oa input TOTAL_PREC signed  datapath results.
REQ-012 SHALL have ports res_valid output 1, res_ready input 1  result handshake.
REQ-013 SHALL have ports res_hit output 1, res_tri_id output TRI_AW, res_t output TOTAL_PREC, res_oa output TOTAL_PREC  nearest-hit result.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE: ray_ready=1; on ray_valid, capture ray_dir and tri_count, clear best (best_hit=0), go ISSUE; if tri_count==0 go DONE directly with res_hit=0.
REQ-016 ISSUE: tri_rd_en=1 every cycle, tri_addr counts 0..tri_count-1, one address per cycle, no bubbles; after address tri_count-1 go DRAIN.
REQ-017 Each issued address SHALL enter a valid/tag shift register of depth PIPE_LAT+1 (1 memory cycle + datapath); the tag emerges aligned with isect_* for that triangle.
REQ-018 DRAIN: no reads; after the tag of the last triangle has emerged and been evaluated, go DONE.
REQ-019 A result is a candidate only when tag valid, isect_hit=1 and isect_oa>0.
REQ-020 Distance is t/oa; candidate replaces best when best_hit=0 or isect_t*best_oa < best_t*isect_oa, computed at 2*TOTAL_PREC signed without truncation.
REQ-021 Equal distances SHALL keep the earlier (lower-index) triangle.
REQ-022 DONE: res_valid=1 with res_* holding best values (res_tri_id, res_t, res_oa = 0 when res_hit=0); stable until res_ready; on res_valid&&res_ready go IDLE.
REQ-023 ray_ready SHALL be 1 only in IDLE; a new ray is not accepted in the cycle DONE completes (one IDLE cycle minimum).
REQ-024 isect_dir SHALL hold the captured direction from handshake until the next handshake.
REQ-025 Latency: for N>=1 triangles, res_valid rises exactly N+PIPE_LAT+2 cycles after the ray handshake edge.
REQ-026 Valid tags arriving outside ISSUE/DRAIN SHALL not exist; tag register SHALL be all-invalid whenever in IDLE.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, ray_ready=1, tri_rd_en=0, tri_addr=0, res_valid=0, res_hit=0, res_tri_id=0, res_t=0, res_oa=0, isect_dir=0, all tags invalid, best cleared.
REQ-028 Reset asserted mid-sweep SHALL abandon the ray; results from in-flight triangles after release SHALL be ignored.

Verification
REQ-029 tri_count=0 -> DONE next cycle, res_hit=0, res_tri_id=0; res_ready=1 returns to IDLE.
REQ-030 tri_count=4, PIPE_LAT=8, hits on ids 1 (t=6,oa=2) and 3 (t=2,oa=1) -> res_hit=1, res_tri_id=3, res_valid at cycle 14 after handshake.
REQ-031 Two hits at equal distance (t=4,oa=2 id 0; t=2,oa=1 id 2) -> res_tri_id=0.
REQ-032 isect_hit=1 with oa=0, or tag invalid -> ignored, res_hit=0.
REQ-033 res_ready held low 10 cycles in DONE -> res_* stable, ray_ready=0 throughout.
REQ-034 rst_n pulsed low during ISSUE at address 5 -> all outputs at reset values immediately; next ray sweeps from address 0 with clean best.

Source files
------------

// File: rtl/triangle_sweep_ctrl.sv
// triangle_sweep_ctrl
// Accepts one ray, streams every triangle address of the scene into the
// intersect datapath, tracks the nearest valid hit by comparing t/oa ratios
// through cross-multiplication, and presents the winner on a result handshake.
module triangle_sweep_ctrl #(
  parameter int TOTAL_PREC = 27,
  parameter int TRI_AW     = 10,
  parameter int PIPE_LAT   = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ray_valid,
  output logic                               ray_ready,
  input  logic signed [3*TOTAL_PREC-1:0]     ray_dir,
  input  logic        [TRI_AW:0]             tri_count,
  output logic                               tri_rd_en,
  output logic        [TRI_AW-1:0]           tri_addr,
  output logic signed [3*TOTAL_PREC-1:0]     isect_dir,
  input  logic                               isect_hit,
  input  logic signed [TOTAL_PREC-1:0]       isect_t,
  input  logic signed [TOTAL_PREC-1:0]       isect_oa,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic                               res_hit,
  output logic        [TRI_AW-1:0]           res_tri_id,
  output logic signed [TOTAL_PREC-1:0]       res_t,
  output logic signed [TOTAL_PREC-1:0]       res_oa
);

  // One memory cycle plus the datapath latency.
  localparam int DEPTH = PIPE_LAT + 1;
  localparam int PW    = 2 * TOTAL_PREC;

  localparam logic [TRI_AW-1:0] ADDR_ONE = 1;
  localparam logic [TRI_AW:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                           state_q, state_d;
  logic        [TRI_AW-1:0]         addr_q, addr_d;
  logic        [TRI_AW:0]           cnt_q, cnt_d;
  logic signed [3*TOTAL_PREC-1:0]   dir_q, dir_d;

  logic        [DEPTH-1:0]          tag_vld_q, tag_vld_d;
  logic        [TRI_AW-1:0]         tag_id_q [DEPTH];
  logic        [TRI_AW-1:0]         tag_id_d [DEPTH];

  logic                             best_hit_q, best_hit_d;
  logic        [TRI_AW-1:0]         best_id_q, best_id_d;
  logic signed [TOTAL_PREC-1:0]     best_t_q, best_t_d;
  logic signed [TOTAL_PREC-1:0]     best_oa_q, best_oa_d;

  logic                             res_valid_q, res_valid_d;
  logic                             res_hit_q, res_hit_d;
  logic        [TRI_AW-1:0]         res_tri_id_q, res_tri_id_d;
  logic signed [TOTAL_PREC-1:0]     res_t_q, res_t_d;
  logic signed [TOTAL_PREC-1:0]     res_oa_q, res_oa_d;

  logic                             emerge_vld;
  logic        [TRI_AW-1:0]         emerge_id;
  logic                             cand;
  logic                             last_addr;

  // Sign-extend a word to the full product width.
  function automatic logic signed [PW-1:0] sext(input logic signed [TOTAL_PREC-1:0] v);
    return $signed({{TOTAL_PREC{v[TOTAL_PREC-1]}}, v});
  endfunction

  // True when t_n/oa_n is strictly nearer than t_b/oa_b (both oa positive).
  // Strict compare keeps the earlier triangle on ties.
  function automatic logic is_closer(input logic signed [TOTAL_PREC-1:0] t_n,
                                     input logic signed [TOTAL_PREC-1:0] oa_n,
                                     input logic signed [TOTAL_PREC-1:0] t_b,
                                     input logic signed [TOTAL_PREC-1:0] oa_b);
    logic signed [PW-1:0] lhs;
    logic signed [PW-1:0] rhs;
    lhs = sext(t_n) * sext(oa_b);
    rhs = sext(t_b) * sext(oa_n);
    return lhs < rhs;
  endfunction

  assign emerge_vld = tag_vld_q[DEPTH-1];
  assign emerge_id  = tag_id_q[DEPTH-1];
  assign cand       = emerge_vld && isect_hit && !isect_oa[TOTAL_PREC-1] && (isect_oa != '0);
  assign last_addr  = (({1'b0, addr_q} + CNT_ONE) == cnt_q);

  assign ray_ready  = (state_q == S_IDLE);
  assign tri_rd_en  = (state_q == S_ISSUE);
  assign tri_addr   = addr_q;
  assign isect_dir  = dir_q;
  assign res_valid  = res_valid_q;
  assign res_hit    = res_hit_q;
  assign res_tri_id = res_tri_id_q;
  assign res_t      = res_t_q;
  assign res_oa     = res_oa_q;

  // Tag shift register: each issued address travels alongside its triangle.
  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = (state_q == S_ISSUE);
    tag_id_d[0]  = addr_q;
    for (int i = 1; i < DEPTH; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // Sweep FSM, best-hit tracking and result register next-state.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    best_hit_d   = best_hit_q;
    best_id_d    = best_id_q;
    best_t_d     = best_t_q;
    best_oa_d    = best_oa_q;
    res_valid_d  = res_valid_q;
    res_hit_d    = res_hit_q;
    res_tri_id_d = res_tri_id_q;
    res_t_d      = res_t_q;
    res_oa_d     = res_oa_q;

    // Tags are only ever valid during ISSUE/DRAIN, so this cannot fire elsewhere.
    if (cand && (!best_hit_q || is_closer(isect_t, isect_oa, best_t_q, best_oa_q))) begin
      best_hit_d = 1'b1;
      best_id_d  = emerge_id;
      best_t_d   = isect_t;
      best_oa_d  = isect_oa;
    end

    unique case (state_q)
      S_IDLE: begin
        if (ray_valid) begin
          dir_d      = ray_dir;
          cnt_d      = tri_count;
          addr_d     = '0;
          best_hit_d = 1'b0;
          best_id_d  = '0;
          best_t_d   = '0;
          best_oa_d  = '0;
          if (tri_count == '0) begin
            state_d      = S_DONE;
            res_valid_d  = 1'b1;
            res_hit_d    = 1'b0;
            res_tri_id_d = '0;
            res_t_d      = '0;
            res_oa_d     = '0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (last_addr) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      S_DRAIN: begin
        // Empty tag pipe means the last triangle was already folded into best.
        if (tag_vld_q == '0) begin
          state_d      = S_DONE;
          res_valid_d  = 1'b1;
          res_hit_d    = best_hit_q;
          res_tri_id_d = best_hit_q ? best_id_q : '0;
          res_t_d      = best_hit_q ? best_t_q  : '0;
          res_oa_d     = best_hit_q ? best_oa_q : '0;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d      = S_IDLE;
          res_valid_d  = 1'b0;
          res_hit_d    = 1'b0;
          res_tri_id_d = '0;
          res_t_d      = '0;
          res_oa_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, best and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      dir_q        <= '0;
      tag_vld_q    <= '0;
      best_hit_q   <= 1'b0;
      best_id_q    <= '0;
      best_t_q     <= '0;
      best_oa_q    <= '0;
      res_valid_q  <= 1'b0;
      res_hit_q    <= 1'b0;
      res_tri_id_q <= '0;
      res_t_q      <= '0;
      res_oa_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      tag_vld_q    <= tag_vld_d;
      best_hit_q   <= best_hit_d;
      best_id_q    <= best_id_d;
      best_t_q     <= best_t_d;
      best_oa_q    <= best_oa_d;
      res_valid_q  <= res_valid_d;
      res_hit_q    <= res_hit_d;
      res_tri_id_q <= res_tri_id_d;
      res_t_q      <= res_t_d;
      res_oa_q     <= res_oa_d;
    end
  end

  // Tag ids are qualified by tag_vld_q, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      tag_id_q[i] <= tag_id_d[i];
    end
  end

endmodule

// File: tb/tb_triangle_sweep_ctrl.sv
// Bench for triangle_sweep_ctrl: a small memory+datapath model answers the
// triangle reads from a per-ray table; a scoreboard queue holds the expected
// result of each ray and a monitor checks each result as it is presented.
module tb_triangle_sweep_ctrl;

  localparam int W  = 27;
  localparam int AW = 10;
  localparam int PL = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  ray_valid;
  logic                  ray_ready;
  logic [3*W-1:0]        ray_dir;
  logic [AW:0]           tri_count;
  logic                  tri_rd_en;
  logic [AW-1:0]         tri_addr;
  logic [3*W-1:0]        isect_dir;
  logic                  isect_hit;
  logic signed [W-1:0]   isect_t;
  logic signed [W-1:0]   isect_oa;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_hit;
  logic [AW-1:0]         res_tri_id;
  logic signed [W-1:0]   res_t;
  logic signed [W-1:0]   res_oa;

  triangle_sweep_ctrl #(.TOTAL_PREC(W), .TRI_AW(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n),
    .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_dir(ray_dir), .tri_count(tri_count),
    .tri_rd_en(tri_rd_en), .tri_addr(tri_addr), .isect_dir(isect_dir),
    .isect_hit(isect_hit), .isect_t(isect_t), .isect_oa(isect_oa),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_tri_id(res_tri_id), .res_t(res_t), .res_oa(res_oa)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Triangle table and memory+datapath model (1 read cycle + PL datapath cycles).
  logic                th [16];
  logic signed [W-1:0] tt [16];
  logic signed [W-1:0] to [16];
  bit                  garbage = 1'b0;
  logic                mv [PL+1];
  logic [AW-1:0]       ma [PL+1];

  always @(posedge clk) begin
    mv[0] <= tri_rd_en;
    ma[0] <= tri_addr;
    for (int i = 1; i <= PL; i++) begin
      mv[i] <= mv[i-1];
      ma[i] <= ma[i-1];
    end
  end

  always_comb begin
    isect_hit = 1'b0;
    isect_t   = '0;
    isect_oa  = '0;
    if (mv[PL] === 1'b1) begin
      isect_hit = th[ma[PL][3:0]];
      isect_t   = tt[ma[PL][3:0]];
      isect_oa  = to[ma[PL][3:0]];
    end else if (garbage) begin
      isect_hit = 1'b1;
      isect_t   = W'(1);
      isect_oa  = W'(1);
    end
  end

  typedef struct {
    logic                hit;
    logic [AW-1:0]       id;
    logic signed [W-1:0] t;
    logic signed [W-1:0] oa;
    int                  lat;
    int                  hold;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_cyc  = 0;
  bit   in_txn  = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 16; i++) begin
      th[i] = 1'b0;
      tt[i] = '0;
      to[i] = '0;
    end
  endtask

  task automatic set_ent(input int i, input logic h, input int t, input int oa);
    th[i] = h;
    tt[i] = W'(t);
    to[i] = W'(oa);
  endtask

  function automatic exp_t mk(input logic h, input int id, input int t, input int oa,
                              input int lat, input int hold);
    exp_t e;
    e.hit  = h;
    e.id   = AW'(id);
    e.t    = W'(t);
    e.oa   = W'(oa);
    e.lat  = lat;
    e.hold = hold;
    return e;
  endfunction

  // Issue one ray, push its expected result, wait for the monitor to retire it.
  task automatic run_ray(input int n, input logic [3*W-1:0] dir, input exp_t e);
    int guard;
    @(negedge clk);
    ray_dir   = dir;
    tri_count = (AW+1)'(n);
    ray_valid = 1'b1;
    guard = 0;
    while (!ray_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ray_accept_timeout", 0, 1);
    hs_cyc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    ray_valid = 1'b0;
    chk("isect_dir_capture", longint'(isect_dir == dir), 1);
    chk("ray_ready_after_hs", longint'(ray_ready), 0);
    if (n > 0) begin
      chk("first_rd_en", longint'(tri_rd_en), 1);
      chk("first_addr", longint'(tri_addr), 0);
    end
    guard = 0;
    while ((sbq.size() != 0 || in_txn || !ray_ready) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) chk("result_timeout", 0, 1);
    chk("isect_dir_held", longint'(isect_dir == dir), 1);
  endtask

  // Monitor: pops the expected result when res_valid rises and checks it.
  initial begin
    exp_t cur;
    int held;
    bit stable;
    logic sh;
    logic [AW-1:0] sid;
    logic signed [W-1:0] st, so;
    res_ready = 1'b0;
    cur = mk(1'b0, 0, 0, 0, 0, 0);
    held = 0;
    stable = 1'b1;
    sh = 1'b0; sid = '0; st = '0; so = '0;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          held = 0;
          stable = 1'b1;
          if (sbq.size() == 0) begin
            chk("unexpected_result", 1, 0);
            cur = mk(1'b0, 0, 0, 0, 0, 0);
          end else begin
            cur = sbq.pop_front();
            chk("res_hit", longint'(res_hit), longint'(cur.hit));
            chk("res_tri_id", longint'(res_tri_id), longint'(cur.id));
            chk("res_t", longint'(res_t), longint'(cur.t));
            chk("res_oa", longint'(res_oa), longint'(cur.oa));
            chk("res_latency", longint'(cyc - hs_cyc), longint'(cur.lat));
          end
          sh = res_hit; sid = res_tri_id; st = res_t; so = res_oa;
        end else begin
          if (res_hit !== sh || res_tri_id !== sid || res_t !== st || res_oa !== so ||
              ray_ready !== 1'b0)
            stable = 1'b0;
        end
        held++;
        if (held > cur.hold && !res_ready) begin
          if (cur.hold > 0) chk("hold_stable", longint'(stable), 1);
          res_ready = 1'b1;
        end
      end else if (in_txn) begin
        in_txn = 1'b0;
        res_ready = 1'b0;
      end
    end
  end

  localparam int MAXP = (1 << 26) - 1;

  // Directed stimulus.
  initial begin
    int guard;
    rst_n     = 1'b0;
    ray_valid = 1'b0;
    ray_dir   = '0;
    tri_count = '0;
    clear_tab();
    repeat (3) @(negedge clk);
    chk("rst_ray_ready", longint'(ray_ready), 1);
    chk("rst_rd_en", longint'(tri_rd_en), 0);
    chk("rst_addr", longint'(tri_addr), 0);
    chk("rst_res_valid", longint'(res_valid), 0);
    chk("rst_res_hit", longint'(res_hit), 0);
    chk("rst_isect_dir", longint'(isect_dir == '0), 1);
    rst_n = 1'b1;
    repeat (PL + 3) @(negedge clk);

    // Zero triangles: DONE right after the handshake, no hit.
    run_ray(0, {27'd1, 27'd2, 27'd3}, mk(1'b0, 0, 0, 0, 0, 0));

    // Two hits, id3 (dist 2) nearer than id1 (dist 3).
    clear_tab();
    set_ent(1, 1'b1, 6, 2);
    set_ent(3, 1'b1, 2, 1);
    run_ray(4, {27'd7, 27'd8, 27'd9}, mk(1'b1, 3, 2, 1, 14, 0));

    // Equal distance: earlier id0 kept over id2.
    clear_tab();
    set_ent(0, 1'b1, 4, 2);
    set_ent(2, 1'b1, 2, 1);
    run_ray(3, {27'd11, 27'd12, 27'd13}, mk(1'b1, 0, 4, 2, 13, 0));

    // oa=0, negative oa, and hits on invalid tag slots are all ignored.
    clear_tab();
    set_ent(0, 1'b1, 1, 0);
    set_ent(1, 1'b0, 1, 1);
    set_ent(2, 1'b1, 1, -1);
    garbage = 1'b1;
    run_ray(3, {27'd21, 27'd22, 27'd23}, mk(1'b0, 0, 0, 0, 13, 0));
    garbage = 1'b0;

    // Negative t is nearer; result held 10 cycles before res_ready.
    clear_tab();
    set_ent(0, 1'b1, 5, 1);
    set_ent(1, 1'b1, -3, 1);
    run_ray(2, {27'd31, 27'd32, 27'd33}, mk(1'b1, 1, -3, 1, 12, 10));

    // Full-width cross products: (M-1)/M just below M/M.
    clear_tab();
    set_ent(0, 1'b1, MAXP, MAXP);
    set_ent(1, 1'b1, MAXP - 1, MAXP);
    run_ray(2, {27'd41, 27'd42, 27'd43}, mk(1'b1, 1, MAXP - 1, MAXP, 12, 0));

    // Reset during ISSUE at address 5 abandons the ray.
    clear_tab();
    for (int i = 0; i < 8; i++) set_ent(i, 1'b1, 1, 1);
    @(negedge clk);
    ray_dir   = {27'd51, 27'd52, 27'd53};
    tri_count = (AW+1)'(8);
    ray_valid = 1'b1;
    @(negedge clk);
    ray_valid = 1'b0;
    guard = 0;
    while (!(tri_rd_en && tri_addr == AW'(5)) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_addr5", longint'(guard < 20), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ray_ready", longint'(ray_ready), 1);
    chk("midrst_rd_en", longint'(tri_rd_en), 0);
    chk("midrst_addr", longint'(tri_addr), 0);
    chk("midrst_res_valid", longint'(res_valid), 0);
    chk("midrst_isect_dir", longint'(isect_dir == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Next ray starts clean from address 0 while old triangles still drain.
    clear_tab();
    set_ent(1, 1'b1, 7, 7);
    run_ray(3, {27'd61, 27'd62, 27'd63}, mk(1'b1, 1, 7, 7, 13, 0));

    chk("scoreboard_empty", longint'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
